// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings for mem_port_arbiter: access modes, FSM states, source IDs
// and a helper that gives the byte offset of the last byte touched by a mode.
package mem_port_arbiter_pkg;

    localparam logic [1:0] MODE_BYTE    = 2'd0;
    localparam logic [1:0] MODE_HALF    = 2'd1;
    localparam logic [1:0] MODE_WORD    = 2'd2;
    localparam logic [1:0] MODE_ILLEGAL = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACCESS  = 2'd1,
        ST_CAPTURE = 2'd2
    } state_t;

    typedef enum logic {
        SRC_IF = 1'b0,
        SRC_LS = 1'b1
    } src_t;

    function automatic logic [1:0] mode_last_offset(input logic [1:0] mode);
        case (mode)
            MODE_BYTE: return 2'd0;
            MODE_HALF: return 2'd1;
            default:   return 2'd3;
        endcase
    endfunction

endpackage

// File: rtl/mem_port_arbiter_access_checker.sv
// Combinational alignment and address-range check for one ByteRAM access;
// err covers illegal mode, misalignment and any byte outside the RAM window.
module access_checker
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned START_ADDRESS = 1024,
    parameter int unsigned STOP_ADDRESS  = START_ADDRESS + 31
) (
    input  logic [31:0] i_addr,
    input  logic [1:0]  i_mode,
    output logic        o_err
);

    logic [32:0] w_first;
    logic [32:0] w_last;
    logic        w_misaligned;
    logic        w_out_of_range;

    always_comb begin
        // 33-bit math so an access near 0xFFFFFFFF cannot wrap back into range
        w_first = {1'b0, i_addr};
        w_last  = w_first + {31'd0, mode_last_offset(i_mode)};
        case (i_mode)
            MODE_BYTE: w_misaligned = 1'b0;
            MODE_HALF: w_misaligned = i_addr[0];
            MODE_WORD: w_misaligned = (i_addr[1:0] != 2'b00);
            default:   w_misaligned = 1'b1;
        endcase
        w_out_of_range = (w_first < 33'(START_ADDRESS)) || (w_last > 33'(STOP_ADDRESS));
        o_err          = w_misaligned || w_out_of_range;
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates fetch and load/store requests onto one ByteRAM, one request per 3 cycles.
// Define ARB_ROUND_ROBIN_EN to alternate grants under contention; default is LSU priority.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned START_ADDRESS = 1024,
    parameter int unsigned STOP_ADDRESS  = START_ADDRESS + 31
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_req_valid,
    output logic        if_req_ready,
    input  logic [31:0] if_req_addr,
    output logic        if_rsp_valid,
    input  logic        ls_req_valid,
    output logic        ls_req_ready,
    input  logic        ls_req_we,
    input  logic [31:0] ls_req_addr,
    input  logic [31:0] ls_req_wdata,
    input  logic [1:0]  ls_req_mode,
    output logic        ls_rsp_valid,
    output logic [31:0] rsp_data,
    output logic        rsp_err,
    output logic [31:0] mem_wr_addr,
    output logic        mem_wr_en,
    output logic [31:0] mem_wr_data,
    output logic [1:0]  mem_wr_mode,
    output logic [31:0] mem_rd_addr,
    output logic        mem_rd_en,
    output logic [1:0]  mem_rd_mode,
    input  logic [31:0] mem_rd_data
);

    state_t      r_state;
    src_t        r_src;
    logic        r_we;
    logic        r_err;
    logic        r_if_rsp_valid;
    logic        r_ls_rsp_valid;
    logic [31:0] r_rsp_data;
    logic        r_rsp_err;
    logic        r_mem_wr_en;
    logic [31:0] r_mem_wr_addr;
    logic [31:0] r_mem_wr_data;
    logic [1:0]  r_mem_wr_mode;
    logic        r_mem_rd_en;
    logic [31:0] r_mem_rd_addr;
    logic [1:0]  r_mem_rd_mode;
`ifdef ARB_ROUND_ROBIN_EN
    src_t        r_last_grant;
`endif

    logic        w_idle;
    logic        w_pick_ls;
    logic        w_grant_ls;
    logic        w_grant_if;
    logic [31:0] w_req_addr;
    logic [1:0]  w_req_mode;
    logic        w_req_err;

    always_comb begin
        w_idle = (r_state == ST_IDLE) && !reset;
`ifdef ARB_ROUND_ROBIN_EN
        w_pick_ls = ls_req_valid && (!if_req_valid || (r_last_grant == SRC_IF));
`else
        w_pick_ls = ls_req_valid;
`endif
        w_grant_ls = w_idle && w_pick_ls;
        w_grant_if = w_idle && if_req_valid && !w_pick_ls;
        w_req_addr = w_pick_ls ? ls_req_addr : if_req_addr;
        w_req_mode = w_pick_ls ? ls_req_mode : MODE_WORD;
    end

    access_checker #(
        .START_ADDRESS(START_ADDRESS),
        .STOP_ADDRESS (STOP_ADDRESS)
    ) u_access_checker (
        .i_addr(w_req_addr),
        .i_mode(w_req_mode),
        .o_err (w_req_err)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= ST_IDLE;
            r_src          <= SRC_LS;
            r_we           <= 1'b0;
            r_err          <= 1'b0;
            r_if_rsp_valid <= 1'b0;
            r_ls_rsp_valid <= 1'b0;
            r_rsp_data     <= '0;
            r_rsp_err      <= 1'b0;
            r_mem_wr_en    <= 1'b0;
            r_mem_wr_addr  <= '0;
            r_mem_wr_data  <= '0;
            r_mem_wr_mode  <= '0;
            r_mem_rd_en    <= 1'b0;
            r_mem_rd_addr  <= '0;
            r_mem_rd_mode  <= '0;
`ifdef ARB_ROUND_ROBIN_EN
            r_last_grant   <= SRC_IF;
`endif
        end else begin
            r_mem_wr_en    <= 1'b0;
            r_mem_rd_en    <= 1'b0;
            r_if_rsp_valid <= 1'b0;
            r_ls_rsp_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_grant_ls || w_grant_if) begin
                        r_src   <= w_grant_ls ? SRC_LS : SRC_IF;
                        r_we    <= w_grant_ls && ls_req_we;
                        r_err   <= w_req_err;
                        r_state <= ST_ACCESS;
`ifdef ARB_ROUND_ROBIN_EN
                        r_last_grant <= w_grant_ls ? SRC_LS : SRC_IF;
`endif
                        // Strobe registers load here so the enable is high exactly in ACCESS
                        if (!w_req_err) begin
                            if (w_grant_ls && ls_req_we) begin
                                r_mem_wr_en   <= 1'b1;
                                r_mem_wr_addr <= w_req_addr;
                                r_mem_wr_data <= ls_req_wdata;
                                r_mem_wr_mode <= w_req_mode;
                            end else begin
                                r_mem_rd_en   <= 1'b1;
                                r_mem_rd_addr <= w_req_addr;
                                r_mem_rd_mode <= w_req_mode;
                            end
                        end
                    end
                end
                ST_ACCESS: begin
                    r_state <= ST_CAPTURE;
                end
                ST_CAPTURE: begin
                    r_rsp_data     <= (r_we || r_err) ? '0 : mem_rd_data;
                    r_rsp_err      <= r_err;
                    r_if_rsp_valid <= (r_src == SRC_IF);
                    r_ls_rsp_valid <= (r_src == SRC_LS);
                    r_state        <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign if_req_ready = w_grant_if;
    assign ls_req_ready = w_grant_ls;
    assign if_rsp_valid = r_if_rsp_valid;
    assign ls_rsp_valid = r_ls_rsp_valid;
    assign rsp_data     = r_rsp_data;
    assign rsp_err      = r_rsp_err;
    assign mem_wr_en    = r_mem_wr_en;
    assign mem_wr_addr  = r_mem_wr_addr;
    assign mem_wr_data  = r_mem_wr_data;
    assign mem_wr_mode  = r_mem_wr_mode;
    assign mem_rd_en    = r_mem_rd_en;
    assign mem_rd_addr  = r_mem_rd_addr;
    assign mem_rd_mode  = r_mem_rd_mode;

endmodule
